dmx512_tx_gen2: RTL and testbench

DMX512_TX_GEN2 -- requirements
Module: dmx512_tx_gen2

---
 rtl/dmx512_tx_gen2.sv | 241 ++++++++++++++++++++++++
 tb/tb_dmx512_tx_gen2.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmx512_tx_gen2.sv
// DMX512 transmitter: BREAK, MAB, start code and data slots fetched from a synchronous slot memory.
// Optional mark-between-slots via `define DMX_TX_MBS_EN (adds mbs_bits input and MBS state).
module dmx512_tx_gen2 #(
    parameter int unsigned CLK_FREQ  = 12000000,
    parameter int unsigned BAUD_RATE = 250000,
    parameter int unsigned MAX_SLOTS = 512,
    parameter int unsigned ADDR_W    = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              start,
    input  logic [9:0]        num_slots,
    input  logic [7:0]        start_code,
    input  logic [7:0]        break_bits,
    input  logic [3:0]        mab_bits,
`ifdef DMX_TX_MBS_EN
    input  logic [3:0]        mbs_bits,
`endif
    input  logic [31:0]       frame_period,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned BIT_CLKS = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CLKS - 1);

    typedef enum logic [2:0] {
        StIdle, StBreak, StMab, StStart, StData, StStop, StGap
`ifdef DMX_TX_MBS_EN
        , StMbs
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        bits_q, bits_d;
    logic [31:0]       pcnt_q, pcnt_d;
    logic [9:0]        slot_q, slot_d;
    logic [7:0]        sh_q, sh_d;
    logic [7:0]        buf_q, buf_d;
    logic [9:0]        n_q, n_d;
    logic [7:0]        sc_q, sc_d;
    logic [7:0]        brk_q, brk_d;
    logic [3:0]        mab_q, mab_d;
    logic [31:0]       per_q, per_d;
`ifdef DMX_TX_MBS_EN
    logic [3:0]        mbs_q, mbs_d;
`endif
    logic              rd_q, rd_d, rd_dly_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              bit_end, first_cyc, go_break, next_slot;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bits_d    = bits_q;
        pcnt_d    = pcnt_q;
        slot_d    = slot_q;
        sh_d      = sh_q;
        n_d       = n_q;
        sc_d      = sc_q;
        brk_d     = brk_q;
        mab_d     = mab_q;
        per_d     = per_q;
`ifdef DMX_TX_MBS_EN
        mbs_d     = mbs_q;
`endif
        rd_d      = 1'b0;
        addr_d    = addr_q;
        done_d    = 1'b0;
        go_break  = 1'b0;
        next_slot = 1'b0;
        bit_end   = (cnt_q == BIT_LAST);
        first_cyc = (cnt_q == '0) && (bits_q == 8'd0);
        // Read data is valid the cycle after the strobe; capture it then.
        buf_d     = rd_dly_q ? mem_rdata : buf_q;

        if (state_q != StIdle) pcnt_d = pcnt_q + 32'd1;
        if (state_q != StIdle && state_q != StGap) begin
            cnt_d  = bit_end ? '0 : cnt_q + 1'b1;
            bits_d = bit_end ? bits_q + 8'd1 : bits_q;
        end

        unique case (state_q)
            StIdle: go_break = enable | start;
            StBreak: begin
                if (bit_end && bits_q == brk_q - 8'd1) begin
                    state_d = StMab;
                    bits_d  = 8'd0;
                end
            end
            StMab: begin
                if (first_cyc && n_q != 10'd0) begin
                    rd_d   = 1'b1;
                    addr_d = '0;
                end
                if (bit_end && bits_q == {4'd0, mab_q - 4'd1}) begin
                    state_d = StStart;
                    bits_d  = 8'd0;
                    slot_d  = 10'd0;
                    sh_d    = sc_q;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    bits_d  = 8'd0;
                end
            end
            StData: begin
                if (bit_end && bits_q == 8'd7) begin
                    state_d = StStop;
                    bits_d  = 8'd0;
                end
            end
            StStop: begin
                // Prefetch the next slot while the stop bits are on the line.
                if (first_cyc && slot_q != n_q) begin
                    rd_d   = 1'b1;
                    addr_d = ADDR_W'(slot_q);
                end
                if (bit_end && bits_q == 8'd1) begin
                    bits_d = 8'd0;
                    if (slot_q == n_q) begin
                        done_d  = 1'b1;
                        state_d = enable ? StGap : StIdle;
                    end
`ifdef DMX_TX_MBS_EN
                    else if (mbs_q != 4'd0) begin
                        state_d = StMbs;
                    end
`endif
                    else begin
                        next_slot = 1'b1;
                    end
                end
            end
`ifdef DMX_TX_MBS_EN
            StMbs: begin
                if (bit_end && bits_q == {4'd0, mbs_q - 4'd1}) begin
                    bits_d    = 8'd0;
                    next_slot = 1'b1;
                end
            end
`endif
            StGap: begin
                if (!enable) state_d = StIdle;
                else if ({1'b0, pcnt_q} + 33'd1 >= {1'b0, per_q}) go_break = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (next_slot) begin
            state_d = StStart;
            slot_d  = slot_q + 10'd1;
            sh_d    = buf_q;
        end

        if (go_break) begin
            state_d = StBreak;
            cnt_d   = '0;
            bits_d  = 8'd0;
            pcnt_d  = 32'd0;
            n_d     = (num_slots > 10'(MAX_SLOTS)) ? 10'(MAX_SLOTS) : num_slots;
            sc_d    = start_code;
            brk_d   = (break_bits < 8'd23) ? 8'd23 : break_bits;
            mab_d   = (mab_bits < 4'd2) ? 4'd2 : mab_bits;
            per_d   = frame_period;
`ifdef DMX_TX_MBS_EN
            mbs_d   = mbs_bits;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bits_q   <= 8'd0;
            pcnt_q   <= 32'd0;
            slot_q   <= 10'd0;
            sh_q     <= 8'd0;
            buf_q    <= 8'd0;
            n_q      <= 10'd0;
            sc_q     <= 8'd0;
            brk_q    <= 8'd0;
            mab_q    <= 4'd0;
            per_q    <= 32'd0;
`ifdef DMX_TX_MBS_EN
            mbs_q    <= 4'd0;
`endif
            rd_q     <= 1'b0;
            rd_dly_q <= 1'b0;
            addr_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bits_q   <= bits_d;
            pcnt_q   <= pcnt_d;
            slot_q   <= slot_d;
            sh_q     <= sh_d;
            buf_q    <= buf_d;
            n_q      <= n_d;
            sc_q     <= sc_d;
            brk_q    <= brk_d;
            mab_q    <= mab_d;
            per_q    <= per_d;
`ifdef DMX_TX_MBS_EN
            mbs_q    <= mbs_d;
`endif
            rd_q     <= rd_d;
            rd_dly_q <= rd_q;
            addr_q   <= addr_d;
            done_q   <= done_d;
        end
    end

    // Line level decoded straight from state so an async reset releases tx at once.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            StBreak, StStart: tx = 1'b0;
            StData:           tx = sh_q[bits_q[2:0]];
            default:          tx = 1'b1;
        endcase
    end

    assign busy       = (state_q != StIdle) && (state_q != StGap);
    assign frame_done = done_q;
    assign mem_rd_en  = rd_q;
    assign mem_addr   = addr_q;

endmodule

// File: tb/tb_dmx512_tx_gen2.sv
// Scoreboard bench for dmx512_tx_gen2: expected frames are queued, a line monitor decodes tx.
// Honours `define DMX_TX_MBS_EN (mbs_bits=2 -> 96 clk mark between slots).
module tb_dmx512_tx_gen2;

`ifdef DMX_TX_MBS_EN
    localparam int GAP = 96;
`else
    localparam int GAP = 0;
`endif

    typedef struct packed {
        logic [31:0] brk;
        logic [31:0] mab;
        logic [31:0] n;
        logic [31:0] interval;
        logic [63:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic [9:0] num_slots = 10'd0;
    logic [7:0] start_code = 8'd0;
    logic [7:0] break_bits = 8'd23;
    logic [3:0] mab_bits = 4'd3;
`ifdef DMX_TX_MBS_EN
    logic [3:0] mbs_bits = 4'd2;
`endif
    logic [31:0] frame_period = 32'd0;
    logic        mem_rd_en;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_rdata = 8'hEE;
    logic        tx, busy, frame_done;

    logic [7:0] mem [16];
    exp_t exp_q[$];
    int total = 0, bad = 0, cyc = 0, done_cnt = 0, last_brk = 0, fd_pulses = 0;
    bit mon_en = 1'b1;

    dmx512_tx_gen2 #(
        .CLK_FREQ (12000000),
        .BAUD_RATE(250000),
        .MAX_SLOTS(3),
        .ADDR_W   (9)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .start       (start),
        .num_slots   (num_slots),
        .start_code  (start_code),
        .break_bits  (break_bits),
        .mab_bits    (mab_bits),
`ifdef DMX_TX_MBS_EN
        .mbs_bits    (mbs_bits),
`endif
        .frame_period(frame_period),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .tx          (tx),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_done) fd_pulses <= fd_pulses + 1;
        // Data only valid the cycle after a strobe; anything else reads as 0xEE.
        mem_rdata <= mem_rd_en ? mem[mem_addr[3:0]] : 8'hEE;
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic measure_run(input logic level, output int n);
        n = 0;
        while (tx === level && n < 30000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int target, input int limit);
        int k = 0;
        while (done_cnt < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("frame_count", done_cnt, target);
    endtask

    task automatic wait_busy(input int limit);
        int k = 0;
        while (busy !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("busy_rise", busy, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: each BREAK pops one expected frame and decodes it bit by bit.
    initial begin : monitor
        exp_t e;
        int n, t;
        logic [10:0] word;
        forever begin
            do @(negedge clk); while (tx !== 1'b0);
            if (!mon_en) begin
                do @(negedge clk); while (tx !== 1'b1);
            end else if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: got break at cycle %0d want none", cyc);
                do @(negedge clk); while (tx !== 1'b1);
            end else begin
                e = exp_q.pop_front();
                t = cyc;
                check("busy_at_break", busy, 1);
                if (e.interval != 0) check("break_interval", t - last_brk, e.interval);
                last_brk = t;
                measure_run(1'b0, n);
                check("break_len", n, e.brk);
                measure_run(1'b1, n);
                check("mab_len", n, e.mab);
                for (int s = 0; s <= int'(e.n); s++) begin
                    if (s > 0) begin
                        measure_run(1'b1, n);
                        check("slot_gap", n, GAP);
                    end
                    wait_cyc(24);
                    for (int i = 0; i < 11; i++) begin
                        word[i] = tx;
                        if (i < 10) wait_cyc(48);
                    end
                    check("slot_word", word, {2'b11, e.data[8*s +: 8], 1'b0});
                    wait_cyc(24);
                end
                check("done_pulse", frame_done, 1);
                check("busy_low_at_done", busy, 0);
                done_cnt++;
            end
        end
    end

    initial begin : stim
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h0F; mem[3] = 8'h81;
        for (int i = 4; i < 16; i++) mem[i] = 8'h00;

        wait_cyc(3);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_addr", mem_addr, 0);
        rst_n = 1'b1;
        wait_cyc(2);

        // Single frame; inputs changed afterwards and a second start while busy must be ignored.
        break_bits = 8'd23; mab_bits = 4'd3; num_slots = 10'd2; start_code = 8'h00;
        exp_q.push_back('{brk: 1104, mab: 144, n: 2, interval: 0,
                          data: {40'h0, 8'h3C, 8'hA5, 8'h00}});
        pulse_start();
        num_slots = 10'd3; start_code = 8'hFF; break_bits = 8'd50; mab_bits = 4'd9;
        wait_cyc(600);
        pulse_start();
        wait_done(1, 6000);

        // Short BREAK/MAB clamp, start code only.
        break_bits = 8'd5; mab_bits = 4'd0; num_slots = 10'd0; start_code = 8'h55;
        exp_q.push_back('{brk: 1104, mab: 96, n: 0, interval: 0, data: 64'h55});
        pulse_start();
        wait_done(2, 4000);

        // num_slots beyond MAX_SLOTS (3) clamps.
        break_bits = 8'd30; mab_bits = 4'd2; num_slots = 10'd7; start_code = 8'h81;
        exp_q.push_back('{brk: 1440, mab: 96, n: 3, interval: 0,
                          data: {32'h0, 8'h0F, 8'h3C, 8'hA5, 8'h81}});
        pulse_start();
        wait_done(3, 6000);

        // Continuous mode with a long period; enable drops inside the second frame.
        break_bits = 8'd23; mab_bits = 4'd3; num_slots = 10'd1; start_code = 8'hC3;
        frame_period = 32'd5000;
        exp_q.push_back('{brk: 1104, mab: 144, n: 1, interval: 0, data: {48'h0, 8'hA5, 8'hC3}});
        exp_q.push_back('{brk: 1104, mab: 144, n: 1, interval: 5000,
                          data: {48'h0, 8'hA5, 8'hC3}});
        enable = 1'b1;
        wait_done(4, 4000);
        wait_busy(4000);
        enable = 1'b0;
        wait_done(5, 4000);
        wait_cyc(6000);
        check("idle_after_enable_drop", busy, 0);
        check("queue_drained", exp_q.size(), 0);

        // Period shorter than the frame: next BREAK one clock after the last stop bit.
        num_slots = 10'd2; start_code = 8'h5A; frame_period = 32'd10;
        exp_q.push_back('{brk: 1104, mab: 144, n: 2, interval: 0,
                          data: {40'h0, 8'h3C, 8'hA5, 8'h5A}});
        exp_q.push_back('{brk: 1104, mab: 144, n: 2, interval: 2833 + 2 * GAP,
                          data: {40'h0, 8'h3C, 8'hA5, 8'h5A}});
        enable = 1'b1;
        wait_done(6, 4000);
        wait_busy(100);
        enable = 1'b0;
        wait_done(7, 4000);
        wait_cyc(100);
        check("idle_after_b2b", busy, 0);

        // Reset during the start bit of slot 3.
        mon_en = 1'b0;
        num_slots = 10'd3; start_code = 8'h00; frame_period = 32'd0;
        pulse_start();
        wait_busy(10);
        wait_cyc(2842 + 3 * GAP);
        check("tx_low_in_slot3", tx, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_rd_en", mem_rd_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(200);
        check("post_rst_tx", tx, 1);
        check("post_rst_busy", busy, 0);
        check("frame_done_pulses", fd_pulses, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
